// File: rtl/lfsr_digit_source.sv
// 4-bit maximal-length Fibonacci LFSR digit source for the 7-segment converter.
// It steps on a prescaled tick in RUN or on a synchronised button edge in PAUSE, and supports a seed load.
module lfsr_digit_source #(
  parameter int         DIV_COUNT = 12000000,
  parameter logic [3:0] SEED      = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step_btn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] dec,
  output logic       new_val,
  output logic       wrap,
  output logic       running
);

  localparam int               CNT_W   = $clog2(DIV_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_COUNT - 1);

  typedef enum logic {PAUSE, RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       run_sync_q, run_sync_d;
  logic [2:0]       step_sync_q, step_sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dec_q, dec_d;
  logic [3:0]       start_q, start_d;
  logic             new_val_q, new_val_d;
  logic             wrap_q, wrap_d;
  logic             running_q, running_d;

  logic       step_ev, tick, do_step;
  logic [3:0] lfsr_nxt, ld_v;

  always_comb begin
    run_sync_d  = {run_sync_q[0], run};
    // Bit 2 holds the previous synchronised level for edge detection.
    step_sync_d = {step_sync_q[1:0], step_btn};
    step_ev     = step_sync_q[1] & ~step_sync_q[2];

    state_d   = run_sync_q[1] ? RUN : PAUSE;
    running_d = (state_d == RUN);

    tick    = (state_q == RUN) && (cnt_q == CNT_MAX);
    do_step = (state_q == RUN) ? tick : step_ev;

    // Counting only continues while staying in RUN; entry and exit both leave it at 0.
    cnt_d = '0;
    if (state_q == RUN && state_d == RUN && !tick) cnt_d = cnt_q + 1'b1;

    lfsr_nxt = {dec_q[2:0], dec_q[3] ^ dec_q[2]};
    ld_v     = (load_val == 4'd0) ? SEED : load_val;

    dec_d     = dec_q;
    start_d   = start_q;
    new_val_d = 1'b0;
    wrap_d    = 1'b0;

    // A load overrides any coincident tick or step and restarts the prescaler.
    if (load) begin
      dec_d     = ld_v;
      start_d   = ld_v;
      cnt_d     = '0;
      new_val_d = 1'b1;
    end else if (do_step) begin
      dec_d     = lfsr_nxt;
      new_val_d = 1'b1;
      wrap_d    = (lfsr_nxt == start_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PAUSE;
      run_sync_q  <= '0;
      step_sync_q <= '0;
      cnt_q       <= '0;
      dec_q       <= SEED;
      start_q     <= SEED;
      new_val_q   <= 1'b0;
      wrap_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_sync_q  <= run_sync_d;
      step_sync_q <= step_sync_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      start_q     <= start_d;
      new_val_q   <= new_val_d;
      wrap_q      <= wrap_d;
      running_q   <= running_d;
    end
  end

  assign dec     = dec_q;
  assign new_val = new_val_q;
  assign wrap    = wrap_q;
  assign running = running_q;

endmodule

// File: tb/tb_lfsr_digit_source.sv
// Directed bench for lfsr_digit_source with DIV_COUNT=4.
// Outputs are sampled on the falling clock edge and inputs are driven there as well.
module tb_lfsr_digit_source;

  logic       clk = 1'b0;
  logic       rst_n, run, step_btn, load;
  logic [3:0] load_val;
  logic [3:0] dec;
  logic       new_val, wrap, running;

  int tests = 0;
  int fails = 0;

  logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                           4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                           4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  lfsr_digit_source #(.DIV_COUNT(4), .SEED(4'b0001)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_btn(step_btn), .load(load),
    .load_val(load_val), .dec(dec), .new_val(new_val), .wrap(wrap), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed dec/nv/wrap/run=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    int idx;
    logic nv_e;
    rst_n = 1'b0; run = 1'b0; step_btn = 1'b0; load = 1'b0; load_val = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state holds for 100 cycles while idle.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("reset_idle", {dec, new_val, wrap, running}, {4'b0001, 3'b000});
    end

    // PAUSE: 15 single steps; the edge lands 3 clocks after the pin rises.
    idx = 0;
    for (int i = 0; i < 15; i++) begin
      step_btn = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (c == 3) idx = (idx + 1) % 15;
        if (c == 4) step_btn = 1'b0;
        chk($sformatf("pause_step%0d_c%0d", i, c), {dec, new_val, wrap, running},
            {seq[idx], (c == 3), (c == 3 && i == 14), 1'b0});
      end
    end

    // RUN: running after 3 clocks, first step 4 clocks later, then every 4 clocks.
    // Step button presses during RUN must be ignored.
    run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      nv_e = (c >= 7) && ((c - 7) % 4 == 0);
      if (nv_e) idx = (idx + 1) % 15;
      if (c == 8)  step_btn = 1'b1;
      if (c == 12) step_btn = 1'b0;
      chk($sformatf("run_c%0d", c), {dec, new_val, wrap, running},
          {seq[idx], nv_e, 1'b0, (c >= 3)});
    end

    // Load 1010 mid-prescale; it becomes the new start value.
    load = 1'b1; load_val = 4'b1010;
    @(negedge clk);
    chk("load_1010", {dec, new_val, wrap, running}, {4'b1010, 3'b101});
    load = 1'b0;
    idx = 7;
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk);
      nv_e = (k % 4 == 0);
      if (nv_e) idx = (idx + 1) % 15;
      chk($sformatf("after_load_k%0d", k), {dec, new_val, wrap, running},
          {seq[idx], nv_e, (k == 60), 1'b1});
    end

    // The prescaler is at its terminal count here; a zero load coincides with the tick.
    load = 1'b1; load_val = 4'b0000;
    @(negedge clk);
    chk("load_zero_on_tick", {dec, new_val, wrap, running}, {4'b0001, 3'b101});
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_zero_load_k%0d", k), {dec, new_val, wrap, running},
          {(k == 4) ? 4'b0010 : 4'b0001, (k == 4), 1'b0, 1'b1});
    end

    // Asynchronous reset between edges, while new_val is high.
    #2 rst_n = 1'b0; run = 1'b0;
    #1 chk("async_reset", {dec, new_val, wrap, running}, {4'b0001, 3'b000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset_pause_c%0d", c), {dec, new_val, wrap, running},
          {4'b0001, 3'b000});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
